// File: rtl/shift_pkg.sv
// Shared types for the shift engine: shift modes and control states.
package shift_pkg;

    typedef enum logic [1:0] {
        LSR = 2'b00,
        SHL = 2'b01,
        ROR = 2'b10,
        ASR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-step shifter: computes the next register value for a mode.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    input  shift_mode_t      mode_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = value_i;
        case (mode_i)
            LSR:     next_o = {serial_i, value_i[WIDTH-1:1]};
            SHL:     next_o = {value_i[WIDTH-2:0], serial_i};
            ROR:     next_o = {value_i[0], value_i[WIDTH-1:1]};
            ASR:     next_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
            default: next_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Shift register with parallel load, single-step shifts and counted
// multi-step shifts (IDLE -> SHIFT -> DONE) in four shift modes.
module shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       Mode,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic             Shift_In,
    output logic             Shift_Out,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Busy,
    output logic             Done
);

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    shift_mode_t      mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    shift_mode_t      live_mode;
    shift_mode_t      step_mode;
    shift_mode_t      out_mode;
    logic [WIDTH-1:0] step_value;
    logic [CNT_W-1:0] start_cnt;

    assign live_mode = shift_mode_t'(Mode);

    // SHIFT runs in the latched mode; IDLE single steps follow the live Mode.
    assign step_mode = (state_q == SHIFT) ? mode_q : live_mode;
    assign out_mode  = (state_q == IDLE) ? live_mode : mode_q;
    assign start_cnt = (Count > WIDTH_CNT) ? WIDTH_CNT : Count;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value_i (data_q),
        .mode_i  (step_mode),
        .serial_i(Shift_In),
        .next_o  (step_value)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    data_d = D;
                end else if (Start) begin
                    mode_d  = live_mode;
                    cnt_d   = start_cnt;
                    state_d = (start_cnt != '0) ? SHIFT : DONE;
                end else if (Shift_En) begin
                    data_d = step_value;
                end
            end
            SHIFT: begin
                data_d = step_value;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            mode_q  <= LSR;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Data_Out  = data_q;
    assign Busy      = (state_q == SHIFT);
    assign Done      = (state_q == DONE);
    assign Shift_Out = (out_mode == SHL) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: tb/tb_shift_engine.sv
// Randomized self-checking bench for shift_engine (WIDTH=8) against an
// arithmetic reference model of the register contents.
module tb_shift_engine;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] D = '0;
    logic [1:0] Mode = '0;
    logic       Shift_En = 1'b0;
    logic       Start = 1'b0;
    logic [3:0] Count = '0;
    logic       Shift_In = 1'b0;
    logic       Shift_Out;
    logic [7:0] Data_Out;
    logic       Busy;
    logic       Done;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] mdl = '0;
    logic [7:0] so_seq = '0;

    shift_engine #(
        .WIDTH(8)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (Load),
        .D        (D),
        .Mode     (Mode),
        .Shift_En (Shift_En),
        .Start    (Start),
        .Count    (Count),
        .Shift_In (Shift_In),
        .Shift_Out(Shift_Out),
        .Data_Out (Data_Out),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode codes: 0 LSR, 1 SHL, 2 ROR, 3 ASR; computed with integer arithmetic.
    function automatic logic [7:0] ref_step(input logic [7:0] v, input int m, input int s);
        int x;
        x = int'(v);
        case (m)
            0:       x = x / 2 + s * 128;
            1:       x = (x * 2) % 256 + s;
            2:       x = x / 2 + (x % 2) * 128;
            default: x = x / 2 + ((x >= 128) ? 128 : 0);
        endcase
        return x[7:0];
    endfunction

    function automatic int exp_so(input logic [7:0] v, input int m);
        return (m == 1) ? int'(v) / 128 : int'(v) % 2;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d, input bit with_shen);
        Load     = 1'b1;
        D        = d;
        Shift_En = with_shen;
        Mode     = 2'($urandom);
        tick();
        Load     = 1'b0;
        Shift_En = 1'b0;
        mdl      = d;
        check_eq("load", 64'(Data_Out), 64'(mdl));
    endtask

    task automatic do_single(input int m, input int s);
        Mode     = 2'(m);
        Shift_In = s[0];
        Shift_En = 1'b1;
        #1;
        check_eq("so_idle", 64'(Shift_Out), 64'(exp_so(mdl, m)));
        tick();
        Shift_En = 1'b0;
        mdl = ref_step(mdl, m, s);
        check_eq("single", 64'(Data_Out), 64'(mdl));
        check_eq("busy_idle", 64'(Busy), 64'd0);
    endtask

    task automatic do_start(input int m, input int cnt, input int sin, input bit rnd_sin, input bit noise);
        int n;
        int s;
        n      = (cnt > 8) ? 8 : cnt;
        so_seq = '0;
        Start    = 1'b1;
        Mode     = 2'(m);
        Count    = 4'(cnt);
        Shift_In = sin[0];
        tick();
        Start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_eq("busy", 64'(Busy), 64'd1);
            check_eq("done_early", 64'(Done), 64'd0);
            check_eq("so_shift", 64'(Shift_Out), 64'(exp_so(mdl, m)));
            so_seq = {so_seq[6:0], Shift_Out};
            s = rnd_sin ? int'($urandom_range(1, 0)) : sin;
            Shift_In = s[0];
            if (noise) begin
                Load     = 1'($urandom);
                D        = 8'($urandom);
                Mode     = 2'($urandom);
                Shift_En = 1'($urandom);
                Start    = 1'($urandom);
                Count    = 4'($urandom);
            end
            tick();
            mdl = ref_step(mdl, m, s);
            check_eq("step_data", 64'(Data_Out), 64'(mdl));
        end
        Load     = 1'b0;
        Start    = 1'b0;
        Shift_En = 1'b0;
        Mode     = 2'($urandom);
        #1;
        check_eq("busy_end", 64'(Busy), 64'd0);
        check_eq("done", 64'(Done), 64'd1);
        check_eq("data_done", 64'(Data_Out), 64'(mdl));
        check_eq("so_done", 64'(Shift_Out), 64'(exp_so(mdl, m)));
        tick();
        check_eq("done_clear", 64'(Done), 64'd0);
        check_eq("data_idle", 64'(Data_Out), 64'(mdl));
    endtask

    initial begin
        #1 Reset = 1'b1;
        #1;
        check_eq("rst_data", 64'(Data_Out), 64'd0);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        tick();
        tick();
        @(negedge Clk);
        Reset = 1'b0;
        mdl   = '0;

        do_load(8'hA5, 1'b0);
        do_start(0, 3, 0, 1'b0, 1'b0);
        check_eq("lsr3", 64'(Data_Out), 64'h14);

        do_load(8'h81, 1'b0);
        do_start(2, 1, 0, 1'b0, 1'b0);
        check_eq("ror1", 64'(Data_Out), 64'hC0);

        do_load(8'h81, 1'b0);
        do_start(2, 8, 0, 1'b0, 1'b0);
        check_eq("ror8", 64'(Data_Out), 64'h81);
        check_eq("ror8_so_seq", 64'(so_seq), 64'h81);

        do_load(8'h80, 1'b0);
        do_start(3, 4, 0, 1'b0, 1'b0);
        check_eq("asr4", 64'(Data_Out), 64'hF8);

        do_load(8'h01, 1'b0);
        do_start(1, 2, 1, 1'b0, 1'b0);
        check_eq("shl2", 64'(Data_Out), 64'h07);

        do_load(8'h3C, 1'b0);
        do_start(0, 12, 0, 1'b0, 1'b0);
        check_eq("lsr_sat", 64'(Data_Out), 64'h00);

        do_load(8'h5A, 1'b0);
        do_start(0, 0, 0, 1'b0, 1'b0);
        check_eq("cnt0", 64'(Data_Out), 64'h5A);

        // Reset in the middle of a counted shift must abort without Done.
        do_load(8'hFF, 1'b0);
        Start    = 1'b1;
        Mode     = 2'd0;
        Count    = 4'd5;
        Shift_In = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        #2 Reset = 1'b1;
        #1;
        check_eq("midrst_data", 64'(Data_Out), 64'd0);
        check_eq("midrst_busy", 64'(Busy), 64'd0);
        check_eq("midrst_done", 64'(Done), 64'd0);
        mdl = '0;
        tick();
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("postrst_done", 64'(Done), 64'd0);
            check_eq("postrst_busy", 64'(Busy), 64'd0);
            check_eq("postrst_data", 64'(Data_Out), 64'd0);
        end

        do_load(8'hA5, 1'b0);
        do_start(0, 3, 0, 1'b0, 1'b1);
        check_eq("noise_lsr3", 64'(Data_Out), 64'h14);

        do_load(8'hC3, 1'b1);
        check_eq("load_wins", 64'(Data_Out), 64'hC3);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(2, 0))
                0:       do_load(8'($urandom), 1'($urandom));
                1:       do_single(int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
                default: do_start(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                                  int'($urandom_range(1, 0)), 1'b1, 1'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 8: data register width; legal values 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1): width of the shift-count input.
REQ-003 Clk  input  1  single clock; all state SHALL change on its rising edge except on reset.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Load  input  1  parallel-load request.
REQ-006 D  input  WIDTH  parallel-load data.
REQ-007 Mode  input  2  shift mode: 00 LSR, 01 SHL, 10 ROR, 11 ASR.
REQ-008 Shift_En  input  1  single-step shift request.
REQ-009 Start  input  1  multi-step shift request.
REQ-010 Count  input  CNT_W  number of steps for Start.
REQ-011 Shift_In  input  1  serial bit entering the register, in LSR and SHL only.
REQ-012 Shift_Out  output  1  bit that leaves on the next step: Data_Out[0] for LSR, ROR and ASR; Data_Out[WIDTH-1] for SHL.
REQ-013 Data_Out  output  WIDTH  register contents.
REQ-014 Busy  output  1  high while a multi-step shift is in progress.
REQ-015 Done  output  1  one-cycle pulse when a multi-step shift completes.

Function
REQ-016 One step per mode:
- LSR: {Shift_In, Data_Out[WIDTH-1:1]}.
- SHL: {Data_Out[WIDTH-2:0], Shift_In}.
- ROR: {Data_Out[0], Data_Out[WIDTH-1:1]}.
- ASR: {Data_Out[WIDTH-1], Data_Out[WIDTH-1:1]}.
REQ-017 States SHALL be IDLE, SHIFT and DONE.
REQ-018 Request priority in IDLE SHALL be Load > Start > Shift_En.
REQ-019 IDLE + Load: Data_Out <= D; state stays IDLE.
REQ-020 IDLE + Shift_En (no Load or Start): one step using the live Mode; state stays IDLE.
REQ-021 IDLE + Start: latch Mode; remaining counter <= min(Count, WIDTH).
- Counter nonzero: go to SHIFT.
- Counter zero: go to DONE with Data_Out unchanged.
REQ-022 SHIFT: each cycle perform one step in the latched mode and decrement the counter; when the counter reaches 0 after a step, go to DONE.
REQ-023 Latency: Start sampled at edge t with N = min(Count, WIDTH) > 0.
- Steps occur at edges t+1 through t+N.
- Busy is high for exactly N cycles.
- Done is high in the cycle following edge t+N.
REQ-024 DONE lasts one cycle, then returns to IDLE; Load, Start and Shift_En SHALL be ignored in DONE.
REQ-025 Load, Start, Shift_En and Mode changes SHALL be ignored in SHIFT; Shift_In SHALL be sampled live on every step.
REQ-026 Shift_Out SHALL use the latched mode in SHIFT and DONE, and the live Mode in IDLE.
REQ-027 Busy SHALL be 1 only in SHIFT; Done SHALL be 1 only in DONE.

Reset
REQ-028 Reset asserted SHALL immediately, without a clock edge, force:
- Data_Out = 0, state = IDLE, counter = 0, latched mode = LSR;
- Busy = 0, Done = 0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no Done pulse.
REQ-030 The first edge after Reset deasserts SHALL be treated as IDLE.

Structure
REQ-031 Package shift_pkg SHALL hold the shift_mode_t enum (LSR, SHL, ROR, ASR) and the state_t enum (IDLE, SHIFT, DONE).
REQ-032 The one-step next-value function SHALL be a combinational sub-module, shift_step (inputs: value, mode, serial-in; output: next value), instantiated once.
REQ-033 Every sequential element SHALL reside in shift_engine.

Verification (WIDTH=8)
REQ-034 Load 0xA5; Start, Mode=LSR, Count=3, Shift_In=0 -> Data_Out=0x14; Busy high 3 cycles; Done pulses once in the 4th cycle.
REQ-035 Load 0x81; Start, ROR, Count=1 -> 0xC0. Repeat with Load 0x81 and Count=8 -> 0x81; Shift_Out sequence 1,0,0,0,0,0,0,1.
REQ-036 Load 0x80; Start, ASR, Count=4 -> 0xF8. Load 0x01; Start, SHL, Shift_In=1, Count=2 -> 0x07.
REQ-037 Load 0x3C; Start, LSR, Count=12 -> Busy for 8 cycles, Data_Out=0x00. Start with Count=0 -> Done in the next cycle, Busy never high, Data_Out unchanged.
REQ-038 Load 0xFF; Start, LSR, Count=5; assert Reset between edges during cycle 2 -> Data_Out=0x00 and Busy=0 before the next edge; no Done pulse.
REQ-039 During SHIFT, pulse Load with D=0x00 and toggle Mode -> both ignored, result matches REQ-034. In IDLE, Load and Shift_En together -> load wins.
